// File: rtl/mont_mul_r2.sv
// Radix-2 Montgomery multiplier: out_data = opA * opB * 2^-N mod opM.
// One multiplier bit per cycle, then a conditional subtract, then a registered result strobe.
module mont_mul_r2 #(
   parameter int DATA_WIDTH = 192
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] opA,
   input  logic [DATA_WIDTH-1:0] opB,
   input  logic [DATA_WIDTH-1:0] opM,
   input  logic                  in_valid,
   output logic                  busy,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data
);

   localparam int N  = DATA_WIDTH;
   localparam int CW = $clog2(N) + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOOP  = 2'd1;
   localparam logic [1:0] S_FINAL = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]    r_state;
   logic [N-1:0]  r_a;
   logic [N-1:0]  r_b;
   logic [N-1:0]  r_m;
   logic [N+1:0]  r_t;
   logic [CW-1:0] r_i;
   logic          r_out_valid;
   logic [N-1:0]  r_out_data;

   logic [N+1:0]  w_t1;
   logic [N+1:0]  w_t2;
   logic [N+1:0]  w_red;

   // r_a is shifted right each iteration, so multiplier bit i always sits at r_a[0].
   always_comb begin
      w_t1  = r_t + (r_a[0] ? {2'b00, r_b} : '0);
      w_t2  = w_t1[0] ? (w_t1 + {2'b00, r_m}) : w_t1;
      w_red = (r_t >= {2'b00, r_m}) ? (r_t - {2'b00, r_m}) : r_t;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_m         <= '0;
         r_t         <= '0;
         r_i         <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         r_out_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a     <= opA;
                  r_b     <= opB;
                  r_m     <= opM;
                  r_t     <= '0;
                  r_i     <= '0;
                  r_state <= S_LOOP;
               end
            end
            S_LOOP: begin
               r_t <= w_t2 >> 1;
               r_a <= r_a >> 1;
               r_i <= r_i + CW'(1);
               if (r_i == CW'(N - 1)) begin
                  r_state <= S_FINAL;
               end
            end
            S_FINAL: begin
               r_t     <= w_red;
               r_state <= S_DONE;
            end
            S_DONE: begin
               r_out_valid <= 1'b1;
               r_out_data  <= r_t[N-1:0];
               r_state     <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy      = (r_state != S_IDLE);
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;

endmodule

// File: tb/tb_mont_mul_r2.sv
// Bench for mont_mul_r2: an 8-bit instance checked every cycle against a latency/value model,
// plus directed cases with literal results and one 192-bit instance.
module tb_mont_mul_r2;

   localparam int N  = 8;
   localparam int BW = 192;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  opA = '0, opB = '0, opM = 8'hF1;
   logic          in_valid = 1'b0;
   logic          busy, out_valid;
   logic [N-1:0]  out_data;

   logic [BW-1:0] bA = '0, bB = '0, bM = '0;
   logic          b_in_valid = 1'b0;
   logic          b_busy, b_out_valid;
   logic [BW-1:0] b_out_data;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mont_mul_r2 #(.DATA_WIDTH(N)) u_dut (
      .clk(clk), .rst_n(rst_n), .opA(opA), .opB(opB), .opM(opM),
      .in_valid(in_valid), .busy(busy), .out_valid(out_valid), .out_data(out_data)
   );

   mont_mul_r2 #(.DATA_WIDTH(BW)) u_big (
      .clk(clk), .rst_n(rst_n), .opA(bA), .opB(bB), .opM(bM),
      .in_valid(b_in_valid), .busy(b_busy), .out_valid(b_out_valid), .out_data(b_out_data)
   );

   task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Result x satisfies x * 2^8 == a * b (mod m); found by search, unique because m is odd.
   function automatic logic [N-1:0] mref(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic [N-1:0] m);
      int p;
      p = (int'(a) * int'(b)) % int'(m);
      for (int x = 0; x < int'(m); x++) begin
         if (((x * 256) % int'(m)) == p) return N'(x);
      end
      return '0;
   endfunction

   // Model: accept when idle, then N+2 busy cycles, result strobed in the following cycle.
   int           m_cnt = 0;
   logic         m_ov = 1'b0;
   logic [N-1:0] m_od = '0;
   logic [N-1:0] m_res = '0;
   bit           started = 0;

   always @(posedge clk) begin
      started = 1;
      if (!rst_n) begin
         m_cnt = 0;
         m_ov  = 1'b0;
         m_od  = '0;
      end else begin
         m_ov = 1'b0;
         if (m_cnt == 1) begin
            m_cnt = 0;
            m_ov  = 1'b1;
            m_od  = m_res;
         end else if (m_cnt > 1) begin
            m_cnt = m_cnt - 1;
         end else if (in_valid) begin
            m_res = mref(opA, opB, opM);
            m_cnt = N + 2;
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("busy", BW'(busy), BW'(m_cnt != 0));
         chk("out_valid", BW'(out_valid), BW'(m_ov));
         chk("out_data", BW'(out_data), BW'(m_od));
      end
   end

   // Called just after an edge with the DUT idle; checks latency, busy length and literal result.
   task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] m,
                         input logic [N-1:0] exp, input string name);
      int lat;
      int nb;
      bit got;
      lat = -1; nb = 0; got = 0;
      opA = a; opB = b; opM = m; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int k = 0; k <= 20 && !got; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
         end
         if (busy) nb++;
         if (out_valid) begin
            got = 1;
            lat = k;
         end
      end
      chk({name, "_latency"}, BW'(lat), BW'(N + 2));
      chk({name, "_busy_cycles"}, BW'(nb), BW'(N + 2));
      chk({name, "_data"}, BW'(out_data), BW'(exp));
   endtask

   initial begin
      logic [N-1:0] m;
      int lat;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(8'h01, 8'h01, 8'hF1, 8'hE1, "one_one");
      run_op(8'h0F, 8'h37, 8'hF1, 8'h37, "r_times_b");
      run_op(8'h00, 8'hAB, 8'hF1, 8'h00, "zero_a");
      run_op(8'hAB, 8'h00, 8'hF1, 8'h00, "zero_b");
      run_op(8'hF0, 8'hF0, 8'hF1, 8'hE1, "m1_sq");

      // Abort at LOOP i=3 with in_valid also asserted during the reset edge.
      opA = 8'h55; opB = 8'h66; opM = 8'hF1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("rst_busy", BW'(busy), '0);
      chk("rst_out_valid", BW'(out_valid), '0);
      chk("rst_out_data", BW'(out_data), '0);
      rst_n = 1'b1; in_valid = 1'b0;
      @(posedge clk); #1;
      chk("rst_drop_in_valid", BW'(busy), '0);
      run_op(8'h01, 8'h01, 8'hF1, 8'hE1, "after_reset");

      // in_valid held high with changing operands.
      in_valid = 1'b1;
      for (int c = 0; c < 60; c++) begin
         opA = N'($urandom % 241); opB = N'($urandom % 241); opM = 8'hF1;
         @(posedge clk); #1;
      end

      // Fully random traffic with random odd moduli >= 128.
      for (int c = 0; c < 2500; c++) begin
         m = N'($urandom_range(64, 127)) * 2 + 1;
         in_valid = ($urandom % 2) == 1;
         opA = (($urandom % 8) == 0) ? '0 : N'($urandom % int'(m));
         opB = (($urandom % 8) == 0) ? '0 : N'($urandom % int'(m));
         opM = m;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      repeat (2 * N + 6) @(posedge clk);
      #1;

      // 192-bit case: opA is R mod P-192, so the result equals opB.
      bM = {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF};
      bA = {64'h0, 64'h1, 64'h1};
      bB = BW'(16'h1234);
      b_in_valid = 1'b1;
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      lat = -1;
      for (int k = 0; k <= 400 && lat < 0; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
         end
         if (b_out_valid) lat = k;
      end
      chk("big_latency", BW'(lat), BW'(BW + 2));
      chk("big_data", b_out_data, BW'(16'h1234));

      @(posedge clk); #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
